mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the pipelined core's instruction-fetch port and its data-memory port. Both requesters use a request/ready handshake. The arbiter registers the granted request, drives the memory-side req/ack handshake, and returns the read data with a one-cycle ready pulse. Data accesses have fixed priority, and a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data ports.
// Optional abort-on-timeout logic is compiled in when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_err,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_err,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  if (MAX_STARVE < 1) begin : g_bad_max_starve
    $error("mem_port_arbiter: MAX_STARVE must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be >= 1");
  end

  localparam int unsigned SC_W = $clog2(MAX_STARVE + 1);
  localparam logic [SC_W-1:0] STARVE_FULL = SC_W'(MAX_STARVE);
  localparam logic [SC_W-1:0] STARVE_ONE  = SC_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q,      state_d;
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            mem_req_q,    mem_req_d;
  logic            mem_we_q,     mem_we_d;
  logic [31:0]     mem_addr_q,   mem_addr_d;
  logic [31:0]     mem_wdata_q,  mem_wdata_d;
  logic [31:0]     if_rdata_q,   if_rdata_d;
  logic [31:0]     dm_rdata_q,   dm_rdata_d;
  logic            if_ready_q,   if_ready_d;
  logic            dm_ready_q,   dm_ready_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 32) ? 32 : TO_RAW);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            if_err_q, if_err_d;
  logic            dm_err_q, dm_err_d;
`endif

  logic starve_full;
  assign starve_full = (starve_cnt_q == STARVE_FULL);

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    if_err_d     = 1'b0;
    dm_err_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Data wins a collision unless fetch has already been passed over MAX_STARVE times.
        if (dm_req && !(if_req && starve_full)) begin
          state_d     = DM_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            starve_cnt_d = starve_cnt_q + STARVE_ONE;
          end
`ifdef ARB_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else if (if_req) begin
          state_d      = IF_ACC;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d     = '0;
`endif
        end
      end

      IF_ACC, DM_ACC: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == IF_ACC) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // An ack on the terminal cycle is taken above, so it beats the timeout.
        else if (to_cnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == IF_ACC) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
            if_err_d   = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_ready_d = 1'b1;
            dm_err_d   = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
`endif
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      if_err_q     <= 1'b0;
      dm_err_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      if_err_q     <= if_err_d;
      dm_err_q     <= dm_err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign busy      = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  assign if_err = if_err_q;
  assign dm_err = dm_err_q;
`else
  assign if_err = 1'b0;
  assign dm_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants and
// responses into queues; a monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  mem_port_arbiter #(
    .MAX_STARVE(4),
    .TIMEOUT   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .if_err   (if_err),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .dm_err   (dm_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  grant_t grant_q[$];
  resp_t  if_q[$];
  resp_t  dm_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem_model [logic [31:0]];
  bit          ack_en;
  int          ack_delay;
  bit          force_ack;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    grant_q.push_back('{addr: addr, we: we, wdata: wdata});
  endtask

  task automatic wait_ready(input bit is_if, input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (is_if ? if_ready : dm_ready) break;
      n++;
      if (n > 2000) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s: no ready within 2000 cycles", name);
        break;
      end
    end
    sync();
  endtask

  task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp_rdata, input string name);
    if_q.push_back('{rdata: exp_rdata, err: 1'b0});
    if_req  = 1'b1;
    if_addr = addr;
    wait_ready(1'b1, name);
  endtask

  task automatic dm_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input string name);
    dm_q.push_back('{rdata: exp_rdata, err: exp_err});
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = wdata;
    wait_ready(1'b0, name);
  endtask

  // Memory responder: acks ack_delay cycles after mem_req rises; force_ack drives a stray ack.
  initial begin
    bit req_seen;
    int req_cycles;
    req_seen   = 1'b0;
    req_cycles = 0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        req_cycles = req_seen ? req_cycles + 1 : 0;
        req_seen   = 1'b1;
      end else begin
        req_seen   = 1'b0;
        req_cycles = 0;
      end
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_req && ack_en && req_cycles >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          mem_rdata           = '0;
        end else begin
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEAD_BEEF;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
      end
    end
  end

  // Monitor: compares each new grant and each ready pulse against the scoreboard queues.
  initial begin
    logic   req_prev;
    grant_t g;
    resp_t  r;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !req_prev) begin
        if (grant_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL grant: unexpected grant at addr 0x%08h, none expected", mem_addr);
        end else begin
          g = grant_q.pop_front();
          check("grant_addr",  mem_addr,       g.addr);
          check("grant_we",    32'(mem_we),    32'(g.we));
          check("grant_wdata", mem_wdata,      g.wdata);
          check("grant_busy",  32'(busy),      32'd1);
        end
      end
      req_prev = mem_req;
      if (if_ready) begin
        if (if_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL if_resp: unexpected if_ready, rdata 0x%08h", if_rdata);
        end else begin
          r = if_q.pop_front();
          check("if_rdata", if_rdata,     r.rdata);
          check("if_err",   32'(if_err),  32'(r.err));
        end
      end
      if (dm_ready) begin
        if (dm_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL dm_resp: unexpected dm_ready, rdata 0x%08h", dm_rdata);
        end else begin
          r = dm_q.pop_front();
          check("dm_rdata", dm_rdata,     r.rdata);
          check("dm_err",   32'(dm_err),  32'(r.err));
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int rdy;

    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    ack_en    = 1'b1;
    ack_delay = 1;
    force_ack = 1'b0;

    mem_model[32'h0000_0100] = 32'h0050_0093;
    mem_model[32'h0000_0104] = 32'h00A0_0113;
    mem_model[32'h0000_0200] = 32'h1234_5678;
    mem_model[32'h0000_0300] = 32'h00C0_0193;
    mem_model[32'h0000_0400] = 32'hAAAA_0001;
    mem_model[32'h0000_0404] = 32'hAAAA_0002;
    mem_model[32'h0000_0408] = 32'hAAAA_0003;
    mem_model[32'h0000_040C] = 32'hAAAA_0004;
    mem_model[32'h0000_0410] = 32'hAAAA_0005;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",   32'(mem_req),  32'd0);
    check("rst_mem_we",    32'(mem_we),   32'd0);
    check("rst_mem_addr",  mem_addr,      32'd0);
    check("rst_mem_wdata", mem_wdata,     32'd0);
    check("rst_if_rdata",  if_rdata,      32'd0);
    check("rst_dm_rdata",  dm_rdata,      32'd0);
    check("rst_if_ready",  32'(if_ready), 32'd0);
    check("rst_dm_ready",  32'(dm_ready), 32'd0);
    check("rst_if_err",    32'(if_err),   32'd0);
    check("rst_dm_err",    32'(dm_err),   32'd0);
    check("rst_busy",      32'(busy),     32'd0);
    sync();
    reset = 1'b1;

    // Single fetch with cycle-exact timing: request in N, ack in N+2, ready in N+3, idle in N+4
    ack_delay = 1;
    exp_grant(32'h100, 1'b0, 32'h0);
    fork
      begin
        if_txn(32'h100, 32'h0050_0093, "single_fetch");
        if_req = 1'b0;
      end
      begin
        @(negedge clk);
        check("fetch_n_mem_req",   32'(mem_req),  32'd0);
        @(negedge clk);
        check("fetch_n1_mem_req",  32'(mem_req),  32'd1);
        check("fetch_n1_busy",     32'(busy),     32'd1);
        @(negedge clk);
        check("fetch_n2_if_ready", 32'(if_ready), 32'd0);
        @(negedge clk);
        check("fetch_n3_if_ready", 32'(if_ready), 32'd1);
        check("fetch_n3_mem_req",  32'(mem_req),  32'd0);
        @(negedge clk);
        check("fetch_n4_if_ready", 32'(if_ready), 32'd0);
        check("fetch_n4_busy",     32'(busy),     32'd0);
      end
    join
    sync();

    // Data read acked in the first mem_req cycle
    ack_delay = 0;
    exp_grant(32'h200, 1'b0, 32'h0);
    dm_txn(1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0, "dm_read_fast");
    dm_req = 1'b0;

    // Collision: data write first, fetch at the next IDLE; the write leaves dm_rdata alone
    ack_delay = 2;
    exp_grant(32'h2000, 1'b1, 32'hCAFE_F00D);
    exp_grant(32'h104,  1'b0, 32'h0);
    fork
      begin
        dm_txn(1'b1, 32'h2000, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, "collision_dm");
        dm_req = 1'b0;
        dm_we  = 1'b0;
      end
      begin
        if_txn(32'h104, 32'h00A0_0113, "collision_if");
        if_req = 1'b0;
      end
    join

    // Read back the written word
    ack_delay = 1;
    exp_grant(32'h2000, 1'b0, 32'h0);
    dm_txn(1'b0, 32'h2000, 32'h0, 32'hCAFE_F00D, 1'b0, "readback");
    dm_req = 1'b0;

    // Starvation: four data grants while fetch waits, then the fetch, then the last data access
    exp_grant(32'h400, 1'b0, 32'h0);
    exp_grant(32'h404, 1'b0, 32'h0);
    exp_grant(32'h408, 1'b0, 32'h0);
    exp_grant(32'h40C, 1'b0, 32'h0);
    exp_grant(32'h300, 1'b0, 32'h0);
    exp_grant(32'h410, 1'b0, 32'h0);
    fork
      begin
        dm_txn(1'b0, 32'h400, 32'h0, 32'hAAAA_0001, 1'b0, "starve_dm0");
        dm_txn(1'b0, 32'h404, 32'h0, 32'hAAAA_0002, 1'b0, "starve_dm1");
        dm_txn(1'b0, 32'h408, 32'h0, 32'hAAAA_0003, 1'b0, "starve_dm2");
        dm_txn(1'b0, 32'h40C, 32'h0, 32'hAAAA_0004, 1'b0, "starve_dm3");
        dm_txn(1'b0, 32'h410, 32'h0, 32'hAAAA_0005, 1'b0, "starve_dm4");
        dm_req = 1'b0;
      end
      begin
        if_txn(32'h300, 32'h00C0_0193, "starve_if");
        if_req = 1'b0;
      end
    join

    // Counter cleared by the fetch grant: the next collision goes to data again
    exp_grant(32'h404, 1'b0, 32'h0);
    exp_grant(32'h100, 1'b0, 32'h0);
    fork
      begin
        dm_txn(1'b0, 32'h404, 32'h0, 32'hAAAA_0002, 1'b0, "post_starve_dm");
        dm_req = 1'b0;
      end
      begin
        if_txn(32'h100, 32'h0050_0093, "post_starve_if");
        if_req = 1'b0;
      end
    join

`ifdef ARB_TIMEOUT_EN
    // Timeout after 8 cycles without ack: ready with err and zero data
    ack_en = 1'b0;
    exp_grant(32'h600, 1'b0, 32'h0);
    fork
      begin
        dm_txn(1'b0, 32'h600, 32'h0, 32'h0, 1'b1, "timeout_dm");
        dm_req = 1'b0;
      end
      begin
        hi = 0;
        repeat (20) begin
          @(negedge clk);
          if (mem_req) hi++;
        end
        check("timeout_req_cycles", 32'(hi), 32'd8);
      end
    join
    sync();
    // Ack on the terminal cycle completes normally
    ack_en    = 1'b1;
    ack_delay = 7;
    exp_grant(32'h200, 1'b0, 32'h0);
    dm_txn(1'b0, 32'h200, 32'h0, 32'h1234_5678, 1'b0, "timeout_race");
    dm_req = 1'b0;
`else
    // Without the timeout the arbiter waits indefinitely for mem_ack
    ack_en = 1'b0;
    exp_grant(32'h600, 1'b0, 32'h0);
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = 32'h600;
    dm_wdata = 32'h0;
    @(negedge clk);
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (mem_req) hi++;
    end
    check("no_timeout_req_cycles", 32'(hi), 32'd1000);
    sync();
    reset  = 1'b0;
    dm_req = 1'b0;
    sync();
    reset = 1'b1;
    @(negedge clk);
    check("no_timeout_reset_mem_req", 32'(mem_req), 32'd0);
    sync();
`endif

    // Reset during DM_ACC aborts the access; a late ack is ignored
    ack_en = 1'b0;
    exp_grant(32'h500, 1'b0, 32'h0);
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = 32'h500;
    dm_wdata = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 10);
    check("abort_mem_req_up", 32'(mem_req), 32'd1);
    sync();
    reset  = 1'b0;
    dm_req = 1'b0;
    sync();
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_req",  32'(mem_req),  32'd0);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_dm_ready", 32'(dm_ready), 32'd0);
    sync();
    force_ack = 1'b1;
    sync();
    force_ack = 1'b0;
    rdy = 0;
    repeat (4) begin
      @(negedge clk);
      if (dm_ready || if_ready || mem_req) rdy++;
    end
    check("late_ack_ignored", 32'(rdy),  32'd0);
    check("late_ack_busy",    32'(busy), 32'd0);
    ack_en = 1'b1;
    sync();

    // Normal operation after the abort
    ack_delay = 1;
    exp_grant(32'h100, 1'b0, 32'h0);
    if_txn(32'h100, 32'h0050_0093, "post_reset_fetch");
    if_req = 1'b0;

    repeat (3) @(negedge clk);
    check("grant_q_empty", 32'(grant_q.size()), 32'd0);
    check("if_q_empty",    32'(if_q.size()),    32'd0);
    check("dm_q_empty",    32'(dm_q.size()),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
